hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Decides each cycle whether the instruction in D must stall, using:
  - Tuse/Tnew register-dependency comparison against the E and M stages;
  - a multiply/divide busy counter that models HI/LO unit occupancy.
- Drives the enable of the PC and F/D register, and the clear of the D/E register.
- E/M and M/W registers are never stalled by this block.

Parameters:
- MULT_LAT, 5, cycles the mult/multu unit stays busy after start.
- DIV_LAT, 10, cycles the div/divu unit stays busy after start.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_rs  in  5  rs field of the D-stage instruction.
- D_rt  in  5  rt field of the D-stage instruction.
- D_Tuse_rs  in  2  cycles until D needs rs (3 = not used).
- D_Tuse_rt  in  2  cycles until D needs rt (3 = not used).
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of the E-stage instruction (0 = none).
- E_Tnew  in  2  cycles until the E-stage result is available.
- M_A3  in  5  destination register of the M-stage instruction.
- M_Tnew  in  2  cycles until the M-stage result is available.
- E_start  in  1  mult/div instruction is in E this cycle.
- E_md_div  in  1  qualifies E_start: 1 = div/divu, 0 = mult/multu.
- PC_en  out  1  PC write enable.
- FD_en  out  1  F/D pipeline register enable.
- DE_clr  out  1  synchronous bubble-insert into the D/E register.
- md_busy  out  1  mult/div unit occupied.
- md_cnt  out  CNT_W  remaining busy cycles.
- md_err  out  1  sticky flag: E_start seen while busy.

Behaviour:
- Register hazard, computed for each source X in {rs, rt}:
  - stall_X = (D_X != 0) && ( (D_X == E_A3 && E_Tnew > D_Tuse_X) || (D_X == M_A3 && M_Tnew > D_Tuse_X) ).
  - Equal Tnew and Tuse means the value can be forwarded, so no stall.
  - Register $0 never stalls.
- Mult/div stall:
  - md_stall = D_is_md && (md_busy || E_start).
  - The start cycle itself stalls a following HI/LO instruction.
- stall = stall_rs | stall_rt | md_stall. All three terms are combinational from the current inputs and state.
- Stall outputs, all combinational:
  - PC_en = ~stall.
  - FD_en = ~stall.
  - DE_clr = stall.
- Busy counter md_cnt, register updated on the rising clk edge:
  - If E_start && md_cnt == 0: load DIV_LAT when E_md_div = 1, else MULT_LAT.
  - Else if md_cnt != 0: decrement by 1. A start arriving while busy is ignored for loading and sets md_err.
  - Else: hold at 0.
  - md_busy = (md_cnt != 0), combinational.
  - With MULT_LAT = 5, md_busy is high for exactly 5 cycles after the start edge (md_cnt = 5, 4, 3, 2, 1), then returns to 0.
- md_err:
  - Set on any clock edge where E_start && md_cnt != 0.
  - Cleared only by reset.
- Reset:
  - Asserting reset immediately forces md_cnt = 0, md_busy = 0, md_err = 0, with no clock required. This also applies mid-countdown.
  - Stall outputs still follow the combinational equations during reset, with md_busy = 0.
  - The first start accepted after reset deasserts is the first E_start sampled on a rising edge.
- No internal state other than md_cnt and md_err. Latency is 0 cycles from hazard inputs to stall outputs.

Test Plan:
- Load-use:
  - Stimulus: E_A3 = 5, E_Tnew = 2, D_rs = 5, D_Tuse_rs = 1.
  - Required: PC_en = 0, FD_en = 0, DE_clr = 1.
  - Next: change E_Tnew to 1. Required: all stall outputs released.
- $0 and forwarding:
  - Stimulus: D_rt = 0 with E_A3 = 0, E_Tnew = 2. Required: no stall.
  - Stimulus: D_rt = 8, M_A3 = 8, M_Tnew = 1, D_Tuse_rt = 1. Required: no stall (equal Tnew/Tuse is forwarded).
- Mult:
  - Stimulus: E_start = 1, E_md_div = 0 for one cycle.
  - Required: md_cnt goes 5, 4, 3, 2, 1, 0 on successive edges; md_busy is high for 5 cycles.
  - Required: with D_is_md = 1 held, stall is high in the start cycle plus those 5 cycles, then drops.
- Div:
  - Stimulus: E_start = 1, E_md_div = 1.
  - Required: md_cnt loads 10 and busy lasts 10 cycles. D_is_md = 0 during this time must never stall.
- Reset mid-operation:
  - Stimulus: reset pulsed asynchronously (between clock edges) when md_cnt = 6.
  - Required: md_cnt = 0 and md_busy = 0 before the next edge. A new mult start after release loads 5.
- Error:
  - Stimulus: E_start while md_cnt = 3.
  - Required: md_err = 1 after the edge, md_cnt = 2 (no reload), md_err remains set until reset.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: Tuse/Tnew register-dependency stall
// plus a HI/LO occupancy counter that holds off mult/div-class instructions in D.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_Tuse_rs,
    input  logic [1:0]       D_Tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_A3,
    input  logic [1:0]       E_Tnew,
    input  logic [4:0]       M_A3,
    input  logic [1:0]       M_Tnew,
    input  logic             E_start,
    input  logic             E_md_div,
    output logic             PC_en,
    output logic             FD_en,
    output logic             DE_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic             md_err
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);

    logic stall_rs;
    logic stall_rt;
    logic md_stall;
    logic stall;

    // A producer stalls D only when its result arrives later than D needs it;
    // equal Tnew/Tuse is covered by forwarding.
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                    ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));
        stall_rt = (D_rt != 5'd0) &&
                   (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                    ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));
        md_busy  = (md_cnt != '0);
        md_stall = D_is_md && (md_busy || E_start);
        stall    = stall_rs || stall_rt || md_stall;
        PC_en    = ~stall;
        FD_en    = ~stall;
        DE_clr   = stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
            md_err <= 1'b0;
        end else begin
            if (E_start && (md_cnt == '0)) begin
                md_cnt <= E_md_div ? DIV_LD : MULT_LD;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
            if (E_start && (md_cnt != '0)) begin
                md_err <= 1'b1;
            end
        end
    end

endmodule
